// File: rtl/regbank_wr_arbiter.sv
// Write-port and debug-port arbiter for the integer register bank: executor, queued load returns, debug.
// Optional statistics counters are enabled with `define REGBANK_WR_ARB_STAT_EN.
module regbank_wr_arbiter #(
  parameter int ABITS      = 6,
  parameter int DBITS      = 64,
  parameter int TAGW       = 3,
  parameter int MEMQ_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_e_valid,
  input  logic [ABITS-1:0] i_e_waddr,
  input  logic [DBITS-1:0] i_e_wdata,
  input  logic [TAGW-1:0]  i_e_wtag,
  output logic             o_e_ready,
  input  logic             i_m_valid,
  input  logic [ABITS-1:0] i_m_waddr,
  input  logic [DBITS-1:0] i_m_wdata,
  input  logic [TAGW-1:0]  i_m_wtag,
  output logic             o_m_ready,
  output logic             o_m_ignored,
  input  logic             i_dport_req_valid,
  input  logic             i_dport_write,
  input  logic [ABITS-1:0] i_dport_addr,
  input  logic [DBITS-1:0] i_dport_wdata,
  output logic             o_dport_req_ready,
  output logic             o_dport_resp_valid,
  input  logic             i_dport_resp_ready,
  output logic [DBITS-1:0] o_dport_rdata,
  output logic [ABITS-1:0] o_waddr,
  output logic             o_wena,
  output logic [TAGW-1:0]  o_wtag,
  output logic [DBITS-1:0] o_wdata,
  output logic             o_inorder,
  input  logic             i_ignored,
  output logic [ABITS-1:0] o_dp_addr,
  output logic             o_dp_ena,
  output logic             o_dp_write,
  output logic [DBITS-1:0] o_dp_wdata,
  input  logic [DBITS-1:0] i_dp_rdata
`ifdef REGBANK_WR_ARB_STAT_EN
  ,
  output logic [31:0]      o_stat_conflicts,
  output logic [15:0]      o_stat_ignored
`endif
);

  localparam int PW = (MEMQ_DEPTH > 1) ? $clog2(MEMQ_DEPTH) : 1;
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(MEMQ_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} dbg_state_e;

  logic [ABITS-1:0] q_addr_q [MEMQ_DEPTH];
  logic [DBITS-1:0] q_data_q [MEMQ_DEPTH];
  logic [TAGW-1:0]  q_tag_q  [MEMQ_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      cnt_q, cnt_d;
  logic [3:0]       starve_m_q, starve_m_d, starve_d_q, starve_d_d;
  dbg_state_e       state_q, state_d;
  logic [ABITS-1:0] dbg_addr_q, dbg_addr_d;
  logic             dbg_write_q, dbg_write_d;
  logic [DBITS-1:0] dbg_wdata_q, dbg_wdata_d;
  logic [DBITS-1:0] rdata_q, rdata_d;

  logic head_vld, fifo_full, dbg_force, force_m, e_grant, pop, push, head_wr, dbg_fire;

  always_comb begin
    head_vld  = (cnt_q != '0);
    fifo_full = (cnt_q == FULL_CNT);
    dbg_force = (state_q == ISSUE) && (starve_d_q == SMAX);
    // A forced debug access outranks a forced load; the load retries next cycle.
    force_m   = head_vld && (starve_m_q == SMAX) && !dbg_force;
    e_grant   = i_e_valid && !force_m && !dbg_force;
    pop       = head_vld && !dbg_force && (force_m || !i_e_valid);
    head_wr   = pop && (q_addr_q[rd_ptr_q] != '0);
    dbg_fire  = (state_q == ISSUE) && !e_grant && !pop;
    o_m_ready = !fifo_full || pop;
    push      = i_m_valid && o_m_ready;
  end

  always_comb begin
    o_e_ready   = e_grant;
    o_wena      = 1'b0;
    o_inorder   = 1'b0;
    o_waddr     = '0;
    o_wdata     = '0;
    o_wtag      = '0;
    o_m_ignored = 1'b0;
    if (e_grant) begin
      o_wena  = 1'b1;
      o_waddr = i_e_waddr;
      o_wdata = i_e_wdata;
      o_wtag  = i_e_wtag;
    end else if (head_wr) begin
      o_wena      = 1'b1;
      o_inorder   = 1'b1;
      o_waddr     = q_addr_q[rd_ptr_q];
      o_wdata     = q_data_q[rd_ptr_q];
      o_wtag      = q_tag_q[rd_ptr_q];
      o_m_ignored = i_ignored;
    end
    o_dp_ena           = dbg_fire;
    o_dp_write         = dbg_fire && dbg_write_q;
    o_dp_addr          = dbg_fire ? dbg_addr_q : '0;
    o_dp_wdata         = dbg_fire ? dbg_wdata_q : '0;
    o_dport_req_ready  = (state_q == IDLE);
    o_dport_resp_valid = (state_q == RESP);
    o_dport_rdata      = rdata_q;
  end

  always_comb begin
    cnt_d      = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    starve_m_d = starve_m_q;
    if (pop)
      starve_m_d = '0;
    else if (head_vld && starve_m_q != SMAX)
      starve_m_d = starve_m_q + 4'd1;
  end

  always_comb begin
    state_d     = state_q;
    dbg_addr_d  = dbg_addr_q;
    dbg_write_d = dbg_write_q;
    dbg_wdata_d = dbg_wdata_q;
    rdata_d     = rdata_q;
    starve_d_d  = starve_d_q;
    case (state_q)
      IDLE: if (i_dport_req_valid) begin
        dbg_addr_d  = i_dport_addr;
        dbg_write_d = i_dport_write;
        dbg_wdata_d = i_dport_wdata;
        starve_d_d  = '0;
        state_d     = ISSUE;
      end
      ISSUE: if (dbg_fire) begin
        rdata_d    = dbg_write_q ? dbg_wdata_q : i_dp_rdata;
        starve_d_d = '0;
        state_d    = RESP;
      end else if (starve_d_q != SMAX) begin
        starve_d_d = starve_d_q + 4'd1;
      end
      RESP: if (i_dport_resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      starve_m_q  <= '0;
      starve_d_q  <= '0;
      state_q     <= IDLE;
      dbg_addr_q  <= '0;
      dbg_write_q <= 1'b0;
      dbg_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q       <= cnt_d;
      starve_m_q  <= starve_m_d;
      starve_d_q  <= starve_d_d;
      state_q     <= state_d;
      dbg_addr_q  <= dbg_addr_d;
      dbg_write_q <= dbg_write_d;
      dbg_wdata_q <= dbg_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Queue storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (push) begin
      q_addr_q[wr_ptr_q] <= i_m_waddr;
      q_data_q[wr_ptr_q] <= i_m_wdata;
      q_tag_q[wr_ptr_q]  <= i_m_wtag;
    end
  end

`ifdef REGBANK_WR_ARB_STAT_EN
  logic [31:0] conflicts_q;
  logic [15:0] ignored_q;
  logic        pend_dbg, conflict;

  always_comb begin
    pend_dbg = (state_q == ISSUE);
    conflict = (i_e_valid && head_vld) || (i_e_valid && pend_dbg) || (head_vld && pend_dbg);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      conflicts_q <= '0;
      ignored_q   <= '0;
    end else begin
      if (conflict) conflicts_q <= conflicts_q + 32'd1;
      if (o_m_ignored && ignored_q != 16'hFFFF) ignored_q <= ignored_q + 16'd1;
    end
  end

  assign o_stat_conflicts = conflicts_q;
  assign o_stat_ignored   = ignored_q;
`endif

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Directed bench for regbank_wr_arbiter: executor path, starvation forcing, load queue, debug FSM, reset.
module tb_regbank_wr_arbiter;
  logic        i_clk = 1'b0;
  logic        i_nrst;
  logic        i_e_valid, i_m_valid, i_dport_req_valid, i_dport_write, i_dport_resp_ready, i_ignored;
  logic [5:0]  i_e_waddr, i_m_waddr, i_dport_addr;
  logic [63:0] i_e_wdata, i_m_wdata, i_dport_wdata, i_dp_rdata;
  logic [2:0]  i_e_wtag, i_m_wtag;
  logic        o_e_ready, o_m_ready, o_m_ignored, o_dport_req_ready, o_dport_resp_valid;
  logic        o_wena, o_inorder, o_dp_ena, o_dp_write;
  logic [63:0] o_dport_rdata, o_wdata, o_dp_wdata;
  logic [5:0]  o_waddr, o_dp_addr;
  logic [2:0]  o_wtag;
`ifdef REGBANK_WR_ARB_STAT_EN
  logic [31:0] o_stat_conflicts;
  logic [15:0] o_stat_ignored;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 i_clk = ~i_clk;

  regbank_wr_arbiter dut (
    .i_clk(i_clk), .i_nrst(i_nrst),
    .i_e_valid(i_e_valid), .i_e_waddr(i_e_waddr), .i_e_wdata(i_e_wdata), .i_e_wtag(i_e_wtag),
    .o_e_ready(o_e_ready),
    .i_m_valid(i_m_valid), .i_m_waddr(i_m_waddr), .i_m_wdata(i_m_wdata), .i_m_wtag(i_m_wtag),
    .o_m_ready(o_m_ready), .o_m_ignored(o_m_ignored),
    .i_dport_req_valid(i_dport_req_valid), .i_dport_write(i_dport_write),
    .i_dport_addr(i_dport_addr), .i_dport_wdata(i_dport_wdata),
    .o_dport_req_ready(o_dport_req_ready), .o_dport_resp_valid(o_dport_resp_valid),
    .i_dport_resp_ready(i_dport_resp_ready), .o_dport_rdata(o_dport_rdata),
    .o_waddr(o_waddr), .o_wena(o_wena), .o_wtag(o_wtag), .o_wdata(o_wdata), .o_inorder(o_inorder),
    .i_ignored(i_ignored),
    .o_dp_addr(o_dp_addr), .o_dp_ena(o_dp_ena), .o_dp_write(o_dp_write), .o_dp_wdata(o_dp_wdata),
    .i_dp_rdata(i_dp_rdata)
`ifdef REGBANK_WR_ARB_STAT_EN
    , .o_stat_conflicts(o_stat_conflicts), .o_stat_ignored(o_stat_ignored)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_nrst = 1'b0;
    i_e_valid = 0; i_e_waddr = 0; i_e_wdata = 0; i_e_wtag = 0;
    i_m_valid = 0; i_m_waddr = 0; i_m_wdata = 0; i_m_wtag = 0;
    i_dport_req_valid = 0; i_dport_write = 0; i_dport_addr = 0; i_dport_wdata = 0;
    i_dport_resp_ready = 0; i_ignored = 0; i_dp_rdata = 0;
    #2;
    chk("rst_m_ready", o_m_ready, 1);
    chk("rst_req_ready", o_dport_req_ready, 1);
    chk("rst_wena", o_wena, 0);
    chk("rst_e_ready", o_e_ready, 0);
    chk("rst_resp_valid", o_dport_resp_valid, 0);
    chk("rst_dp_ena", o_dp_ena, 0);
    cyc(); cyc();
    i_nrst = 1'b1;

    // Executor-only write
    cyc();
    i_e_valid = 1; i_e_waddr = 5; i_e_wdata = 64'h1234; i_e_wtag = 2;
    #1;
    chk("t1_wena", o_wena, 1);
    chk("t1_inorder", o_inorder, 0);
    chk("t1_e_ready", o_e_ready, 1);
    chk("t1_waddr", o_waddr, 5);
    chk("t1_wdata", o_wdata, 64'h1234);
    chk("t1_wtag", o_wtag, 2);

    // Load starved by a continuously valid executor
    cyc();
    i_e_waddr = 7; i_e_wdata = 64'h77;
    i_m_valid = 1; i_m_waddr = 10; i_m_wdata = 64'hBEEF; i_m_wtag = 1;
    #1;
    chk("t2_c0_m_ready", o_m_ready, 1);
    chk("t2_c0_inorder", o_inorder, 0);
    cyc();
    i_m_valid = 0;
    #1;
    chk("t2_c1_e_ready", o_e_ready, 1);
    chk("t2_c1_inorder", o_inorder, 0);
    for (int k = 2; k <= 4; k++) begin
      cyc(); #1;
      chk("t2_wait_e_ready", o_e_ready, 1);
      chk("t2_wait_waddr", o_waddr, 7);
    end
    cyc(); #1;
    chk("t2_c5_e_ready", o_e_ready, 0);
    chk("t2_c5_wena", o_wena, 1);
    chk("t2_c5_inorder", o_inorder, 1);
    chk("t2_c5_waddr", o_waddr, 10);
    chk("t2_c5_wdata", o_wdata, 64'hBEEF);
    chk("t2_c5_wtag", o_wtag, 1);
    cyc(); #1;
    chk("t2_c6_e_ready", o_e_ready, 1);
    chk("t2_c6_inorder", o_inorder, 0);
    i_e_valid = 0;

    // Three back-to-back loads, executor idle; x0 popped silently
    cyc();
    i_m_valid = 1; i_m_waddr = 3; i_m_wdata = 64'h33; i_m_wtag = 3;
    #1;
    chk("t3_c0_wena", o_wena, 0);
    chk("t3_c0_m_ready", o_m_ready, 1);
    cyc();
    i_m_waddr = 0; i_m_wdata = 64'h44;
    #1;
    chk("t3_c1_wena", o_wena, 1);
    chk("t3_c1_waddr", o_waddr, 3);
    chk("t3_c1_inorder", o_inorder, 1);
    chk("t3_c1_m_ready", o_m_ready, 1);
    cyc();
    i_m_waddr = 4; i_m_wdata = 64'h55;
    #1;
    chk("t3_c2_x0_wena", o_wena, 0);
    chk("t3_c2_m_ready", o_m_ready, 1);
    cyc();
    i_m_valid = 0;
    #1;
    chk("t3_c3_wena", o_wena, 1);
    chk("t3_c3_waddr", o_waddr, 4);
    chk("t3_c3_wdata", o_wdata, 64'h55);
    cyc(); #1;
    chk("t3_c4_empty_wena", o_wena, 0);

    // Debug read of x1 forced through continuous executor writes
    i_e_valid = 1; i_e_waddr = 8;
    i_dport_req_valid = 1; i_dport_write = 0; i_dport_addr = 1;
    #1;
    chk("t4_c0_req_ready", o_dport_req_ready, 1);
    chk("t4_c0_dp_ena", o_dp_ena, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      i_dport_req_valid = 0; i_dp_rdata = 64'hDEAD;
      #1;
      chk("t4_wait_dp_ena", o_dp_ena, 0);
      chk("t4_wait_e_ready", o_e_ready, 1);
    end
    cyc();
    i_dp_rdata = 64'hABCD;
    #1;
    chk("t4_c5_dp_ena", o_dp_ena, 1);
    chk("t4_c5_dp_write", o_dp_write, 0);
    chk("t4_c5_dp_addr", o_dp_addr, 1);
    chk("t4_c5_e_ready", o_e_ready, 0);
    chk("t4_c5_wena", o_wena, 0);
    cyc();
    i_dp_rdata = 64'h9999;
    #1;
    chk("t4_c6_resp_valid", o_dport_resp_valid, 1);
    chk("t4_c6_rdata", o_dport_rdata, 64'hABCD);
    chk("t4_c6_dp_ena", o_dp_ena, 0);
    chk("t4_c6_e_ready", o_e_ready, 1);
    cyc(); #1;
    chk("t4_c7_resp_held", o_dport_resp_valid, 1);
    chk("t4_c7_rdata_held", o_dport_rdata, 64'hABCD);
    i_dport_resp_ready = 1;
    cyc();
    i_dport_resp_ready = 0; i_e_valid = 0;
    #1;
    chk("t4_done_resp_valid", o_dport_resp_valid, 0);
    chk("t4_done_req_ready", o_dport_req_ready, 1);

    // Debug write to x0 on an idle write port
    i_dport_req_valid = 1; i_dport_write = 1; i_dport_addr = 0; i_dport_wdata = 64'h77;
    cyc();
    i_dport_req_valid = 0;
    #1;
    chk("tw_dp_ena", o_dp_ena, 1);
    chk("tw_dp_write", o_dp_write, 1);
    chk("tw_dp_addr", o_dp_addr, 0);
    chk("tw_dp_wdata", o_dp_wdata, 64'h77);
    i_dport_resp_ready = 1;
    cyc(); #1;
    chk("tw_resp_valid", o_dport_resp_valid, 1);
    chk("tw_rdata", o_dport_rdata, 64'h77);
    cyc();
    i_dport_resp_ready = 0;

    // Load dropped by the bank
    i_m_valid = 1; i_m_waddr = 9; i_m_wdata = 64'h99; i_m_wtag = 5;
    cyc();
    i_m_valid = 0; i_ignored = 1;
    #1;
    chk("t5_ignored_pulse", o_m_ignored, 1);
    chk("t5_wena", o_wena, 1);
    cyc(); #1;
    chk("t5_ignored_low", o_m_ignored, 0);
    i_ignored = 0;
`ifdef REGBANK_WR_ARB_STAT_EN
    chk("t5_stat_ignored", o_stat_ignored, 1);
`endif

    // Fill queue, push+pop at full, debug in RESP, then async reset
    cyc();
    i_e_valid = 1;
    i_m_valid = 1; i_m_waddr = 11; i_m_wdata = 64'hA1;
    i_dport_req_valid = 1; i_dport_write = 0; i_dport_addr = 2;
    cyc();
    i_m_waddr = 12; i_m_wdata = 64'hB2; i_dport_req_valid = 0;
    #1;
    chk("t6_c1_m_ready", o_m_ready, 1);
    cyc();
    i_m_valid = 0;
    #1;
    chk("t6_c2_full", o_m_ready, 0);
    cyc(); cyc();
    cyc();
    i_dp_rdata = 64'h2222;
    #1;
    chk("t6_c5_dp_ena", o_dp_ena, 1);
    chk("t6_c5_wena", o_wena, 0);
    chk("t6_c5_e_ready", o_e_ready, 0);
    cyc();
    i_m_valid = 1; i_m_waddr = 13; i_m_wdata = 64'hC3;
    #1;
    chk("t6_c6_m_ready_popfull", o_m_ready, 1);
    chk("t6_c6_waddr", o_waddr, 11);
    chk("t6_c6_inorder", o_inorder, 1);
    chk("t6_c6_resp_valid", o_dport_resp_valid, 1);
    chk("t6_c6_rdata", o_dport_rdata, 64'h2222);
    cyc();
    i_m_valid = 0;
    #1;
    chk("t6_c7_full", o_m_ready, 0);
    i_e_valid = 0;
    #1;
    i_nrst = 1'b0;
    #1;
    chk("t6_rst_wena", o_wena, 0);
    chk("t6_rst_resp_valid", o_dport_resp_valid, 0);
    chk("t6_rst_m_ready", o_m_ready, 1);
    chk("t6_rst_req_ready", o_dport_req_ready, 1);
    cyc();
    i_nrst = 1'b1;
    cyc(); #1;
    chk("t6_post_wena", o_wena, 0);
    chk("t6_post_resp_valid", o_dport_resp_valid, 0);
    chk("t6_post_dp_ena", o_dp_ena, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
